dac_seq_ctrl: RTL

DAC_SEQ_CTRL -- requirements
Module: dac_seq_ctrl

---
 rtl/dac_seq_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dac_seq_ctrl.sv
// dac_seq_ctrl: sequences X/Y channel codes onto a shared DAC bus.
// Requests are edge-detected, batched per round and acknowledged with a mask.
module dac_seq_ctrl #(
    parameter int NUM_DAC = 4,
    parameter int DATA_W  = 14,
    parameter int TIME_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2*NUM_DAC*DATA_W-1:0]   dac_val,
    input  logic [2*NUM_DAC-1:0]          dac_req,
    input  logic [TIME_W-1:0]             reg_dac_time,
    output logic [NUM_DAC*DATA_W-1:0]     dac_data,
    output logic                          dac_sel,
    output logic                          dac_wrt,
    output logic                          dac_clk,
    output logic                          dac_ack,
    output logic [2*NUM_DAC-1:0]          ack_mask,
    output logic                          busy
);

    localparam int CH = 2 * NUM_DAC;
    localparam int XW = NUM_DAC * DATA_W;
    localparam int SW = CH * DATA_W;

    typedef enum logic [2:0] {
        IDLE, LOAD, WR_X1, WR_X2, WR_Y1, WR_Y2, SETTLE, ACK
    } state_t;

    state_t          state_q, state_d;
    logic [CH-1:0]   req_q, req_d;
    logic [CH-1:0]   pend_q, pend_d;
    logic [CH-1:0]   mask_q, mask_d;
    logic [CH-1:0]   ack_mask_q, ack_mask_d;
    logic [CH-1:0]   edge_w;
    logic [SW-1:0]   shadow_q, shadow_d;
    logic [TIME_W-1:0] settle_q, settle_d;
    logic [TIME_W-1:0] cnt_q, cnt_d;
    logic [XW-1:0]   data_q, data_d;
    logic            sel_q, sel_d;
    logic            wrt_q, wrt_d;
    logic            dclk_q, dclk_d;
    logic            ack_q, ack_d;

    assign edge_w = dac_req & ~req_q;
    assign req_d  = dac_req;

    // Next-state logic: pending bookkeeping, capture, settle countdown.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q | edge_w;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pend_q != '0) state_d = LOAD;
            end
            LOAD: begin
                mask_d   = pend_q;
                settle_d = reg_dac_time;
                for (int k = 0; k < CH; k++) begin
                    if (pend_q[k]) begin
                        shadow_d[k*DATA_W +: DATA_W] =
                            dac_val[k*DATA_W +: DATA_W];
                    end
                end
                // a fresh edge in this cycle survives the clear
                pend_d  = edge_w;
                state_d = WR_X1;
            end
            WR_X1: state_d = WR_X2;
            WR_X2: state_d = WR_Y1;
            WR_Y1: state_d = WR_Y2;
            WR_Y2: begin
                cnt_d   = settle_q;
                state_d = SETTLE;
            end
            SETTLE: begin
                // zero settle behaves as one cycle
                if (cnt_q <= TIME_W'(1)) state_d = ACK;
                else cnt_d = cnt_q - TIME_W'(1);
            end
            ACK: begin
                state_d = (pend_q != '0) ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered bus outputs, decoded from the state being entered.
    always_comb begin
        data_d     = data_q;
        sel_d      = sel_q;
        wrt_d      = 1'b0;
        dclk_d     = 1'b0;
        ack_d      = 1'b0;
        ack_mask_d = ack_mask_q;
        unique case (state_d)
            WR_X1: begin
                data_d = shadow_d[XW-1:0];
                sel_d  = 1'b0;
            end
            WR_X2: wrt_d = 1'b1;
            WR_Y1: begin
                data_d = shadow_d[SW-1:XW];
                sel_d  = 1'b1;
            end
            WR_Y2: begin
                wrt_d  = 1'b1;
                dclk_d = 1'b1;
            end
            ACK: begin
                ack_d      = 1'b1;
                ack_mask_d = mask_q;
            end
            default: ;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
            shadow_q   <= '0;
            settle_q   <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            sel_q      <= 1'b0;
            wrt_q      <= 1'b0;
            dclk_q     <= 1'b0;
            ack_q      <= 1'b0;
            ack_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            shadow_q   <= shadow_d;
            settle_q   <= settle_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            wrt_q      <= wrt_d;
            dclk_q     <= dclk_d;
            ack_q      <= ack_d;
            ack_mask_q <= ack_mask_d;
        end
    end

    assign dac_data = data_q;
    assign dac_sel  = sel_q;
    assign dac_wrt  = wrt_q;
    assign dac_clk  = dclk_q;
    assign dac_ack  = ack_q;
    assign ack_mask = ack_mask_q;
    assign busy     = (state_q != IDLE);

endmodule
